// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: single-beat writes, timed reads.
// Define SRAM_BURST_EN to add req_len multi-beat incrementing reads.
module sram_ctrl #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int WR_WAIT = 2,
  parameter int RD_WAIT = 3,
  parameter int LEN_W   = 8,
  localparam int NBE    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [NBE-1:0]    req_be,
`ifdef SRAM_BURST_EN
  input  logic [LEN_W-1:0]  req_len,
`endif
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [NBE-1:0]    sram_be_n
);

  localparam int CMAX  = (WR_WAIT > RD_WAIT) ? WR_WAIT : RD_WAIT;
  localparam int CNT_W = $clog2(CMAX + 1);

  if (WR_WAIT < 1 || RD_WAIT < 1 || LEN_W < 1) begin : g_bad_wait
    $error("sram_ctrl: WR_WAIT, RD_WAIT and LEN_W must be >= 1");
  end
  if (DATA_W % 8 != 0) begin : g_bad_dw
    $error("sram_ctrl: DATA_W must be a multiple of 8");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_ACCESS
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NBE-1:0]    be_n_q, be_n_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              last_beat;
`ifdef SRAM_BURST_EN
  logic [LEN_W-1:0]  len_q, len_d;
`endif

`ifdef SRAM_BURST_EN
  assign last_beat = (len_q == '0);
`else
  assign last_beat = 1'b1;
`endif

  // Pin values are computed for the state being entered, then registered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_n_d     = be_n_q;
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    dq_oe_d    = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
`ifdef SRAM_BURST_EN
    len_d      = len_q;
`endif
    unique case (state_q)
      IDLE: begin
        be_n_d = '1;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          ce_n_d  = 1'b0;
`ifdef SRAM_BURST_EN
          len_d   = req_len;
`endif
          if (req_write) begin
            state_d = WR_SETUP;
            be_n_d  = ~req_be;
            dq_oe_d = 1'b1;
          end else begin
            state_d = RD_ACCESS;
            be_n_d  = '0;
            oe_n_d  = 1'b0;
          end
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = '0;
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        we_n_d  = 1'b0;
      end
      WR_PULSE: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        if (cnt_q == CNT_W'(WR_WAIT - 1)) begin
          state_d = WR_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          we_n_d = 1'b0;
        end
      end
      WR_HOLD: begin
        state_d = IDLE;
        be_n_d  = '1;
      end
      RD_ACCESS: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        if (cnt_q == CNT_W'(RD_WAIT - 1)) begin
          cnt_d      = '0;
          rd_valid_d = 1'b1;
          rd_data_d  = sram_dq_in;
          if (last_beat) begin
            state_d = IDLE;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            be_n_d  = '1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
`ifdef SRAM_BURST_EN
            len_d  = len_q - LEN_W'(1);
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_n_q     <= '1;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
`ifdef SRAM_BURST_EN
      len_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_n_q     <= be_n_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      dq_oe_q    <= dq_oe_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
`ifdef SRAM_BURST_EN
      len_q      <= len_d;
`endif
    end
  end

  assign req_ready   = (state_q == IDLE) && !reset;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = wdata_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_be_n   = be_n_q;

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 18, SRAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, data width, multiple of 8; lanes NBE = DATA_W/8.
REQ-003 The block SHALL have parameter WR_WAIT, default 2, WE_n low-pulse length in cycles, minimum 1.
REQ-004 The block SHALL have parameter RD_WAIT, default 3, OE_n-to-capture cycles, minimum 1.
REQ-005 The block SHALL have parameter LEN_W, default 8, burst-length width, used only with SRAM_BURST_EN.
REQ-006 The block SHALL have ports: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-007 The block SHALL have ports: req_valid  in  1  request present; req_ready  out  1  request accepted when both high.
REQ-008 The block SHALL have ports: req_write  in  1  1=write 0=read; req_addr  in  ADDR_W  word address; req_wdata  in  DATA_W  write data; req_be  in  NBE  byte enables, active high.
REQ-009 The block SHALL have port req_len  in  LEN_W  read beats minus one, present only with SRAM_BURST_EN.
REQ-010 The block SHALL have ports: rd_valid  out  1  one-cycle read-data strobe; rd_data  out  DATA_W  read data.
REQ-011 The block SHALL have pins: sram_addr  out  ADDR_W; sram_dq_in  in  DATA_W; sram_dq_out  out  DATA_W; sram_dq_oe  out  1  pad drive enable.
REQ-012 The block SHALL have pins: sram_ce_n, sram_oe_n, sram_we_n  out  1 each, active low; sram_be_n  out  NBE  active-low lane select.

Function
REQ-013 req_ready SHALL equal (state==IDLE) AND NOT reset, combinationally; all other outputs SHALL be registered.
REQ-014 On accept, req_addr, req_wdata, req_be, req_write (and req_len) SHALL be latched; inputs are don't-care afterwards.
REQ-015 States SHALL be IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS; IDLE holds ce_n=oe_n=we_n=1, dq_oe=0.
REQ-016 Write: WR_SETUP 1 cycle (ce_n=0, dq_oe=1, addr/data/be_n driven, we_n=1); WR_PULSE WR_WAIT cycles (we_n=0); WR_HOLD 1 cycle (we_n=1, dq_oe=1, data held); then IDLE.
REQ-017 A write SHALL occupy WR_WAIT+2 cycles from accept edge to req_ready high; sram_be_n SHALL be ~req_be during the write.
REQ-018 Read: RD_ACCESS RD_WAIT cycles with ce_n=0, oe_n=0, dq_oe=0, be_n all 0; on its last edge sram_dq_in SHALL be captured into rd_data with rd_valid=1 for exactly the following cycle.
REQ-019 A single read SHALL occupy RD_WAIT cycles; rd_valid SHALL coincide with the first IDLE cycle.
REQ-020 dq_oe and oe_n=0 SHALL never be asserted in the same cycle; we_n and oe_n SHALL never both be low.
REQ-021 rd_data SHALL hold its last value until the next capture; a req_be of all zero SHALL still run the full write cycle with no lane enabled.

Reset
REQ-022 Reset SHALL force, at the next edge, state=IDLE, ce_n=oe_n=we_n=1, be_n all 1, dq_oe=0, rd_valid=0, rd_data=0, counters 0.
REQ-023 Reset mid-operation SHALL abort it without completing the access or asserting rd_valid; req_ready SHALL be 0 throughout reset.
REQ-024 Initial values SHALL equal reset values.

Configuration
REQ-025 Macro SRAM_BURST_EN: when defined, a read SHALL perform req_len+1 consecutive RD_ACCESS beats, address incrementing by 1 per beat, wrapping at 2^ADDR_W, ce_n held low between beats, one rd_valid per beat, total RD_WAIT*(req_len+1) cycles.
REQ-026 With SRAM_BURST_EN, writes SHALL remain single-beat and ignore req_len.
REQ-027 Without SRAM_BURST_EN, port req_len SHALL be absent and every read SHALL be single-beat.

Verification (defaults unless stated)
REQ-028 Write addr 0x00010, data 0xA5C3, be 2'b11 -> we_n low exactly 2 cycles, dq_oe high 4 cycles, req_ready back after 4 cycles; model memory holds 0xA5C3.
REQ-029 Read 0x00010 with model returning 0xA5C3 -> oe_n low 3 cycles, rd_valid high 1 cycle with rd_data=0xA5C3, req_ready high same cycle.
REQ-030 Write be 2'b01 data 0xFFFF over 0x1234 -> sram_be_n=2'b10; readback 0x12FF.
REQ-031 Reset asserted on 2nd WR_PULSE cycle -> next edge we_n=1, dq_oe=0, ce_n=1; no rd_valid; req_ready high first cycle after reset drops.
REQ-032 SRAM_BURST_EN, read addr 0x3FFFE, req_len 3 -> addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001; 4 rd_valid pulses 3 cycles apart; ce_n low 12 contiguous cycles.
REQ-033 Back-to-back read then write with req_valid held -> oe_n and dq_oe never overlap; assertion checks REQ-020 every cycle.
